// File: rtl/riscv_mem_defs_pkg.sv
// Shared MEM-stage definitions: funct3 access codes, responder FSM encodings
// and the captured request payload.
package riscv_mem_defs;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef struct packed {
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Stores only support B/H/W; loads additionally allow the unsigned forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    logic ok;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store enables/shift, load
// extract/extension, and alignment/funct3 legality.
module dmem_lane_align
  import riscv_mem_defs::*;
(
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [3:0]        be_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic [DATA_W-1:0] rdata_c,
  output logic              misalign_c,
  output logic              bad_f3_c
);

  logic [4:0]        shamt;
  logic [DATA_W-1:0] rsh;

  assign shamt = {addr_lo, 3'b000};
  assign rsh   = rword >> shamt;

  always_comb begin
    be_c       = 4'b0000;
    wdata_c    = wdata << shamt;
    rdata_c    = '0;
    misalign_c = 1'b0;
    bad_f3_c   = ~f3_legal(we, funct3);
    case (funct3)
      F3_B: begin
        be_c    = 4'b0001 << addr_lo;
        rdata_c = {{24{rsh[7]}}, rsh[7:0]};
      end
      F3_BU: begin
        be_c    = 4'b0001 << addr_lo;
        rdata_c = {24'd0, rsh[7:0]};
      end
      F3_H: begin
        misalign_c = addr_lo[0];
        be_c       = 4'b0011 << addr_lo;
        rdata_c    = {{16{rsh[15]}}, rsh[15:0]};
      end
      F3_HU: begin
        misalign_c = addr_lo[0];
        be_c       = 4'b0011 << addr_lo;
        rdata_c    = {16'd0, rsh[15:0]};
      end
      F3_W: begin
        misalign_c = (addr_lo != 2'b00);
        be_c       = 4'b1111;
        rdata_c    = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory slave: single outstanding request, fixed wait states,
// lane-masked stores and extended loads, with a busy flag for the hazard unit.
module dmem_responder
  import riscv_mem_defs::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [1:0]        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  mem_req_t          cap, cap_d, req_c, acc_c;
  logic              rsp_valid_d, rsp_err_d, req_ready_d, busy_d;
  logic [DATA_W-1:0] rsp_rdata_d;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [AW-1:0]     word_idx_c;
  logic [DATA_W-1:0] rword_c, wdata_sh_c, rdata_ext_c;
  logic [3:0]        be_c;
  logic              misalign_c, bad_f3_c, oor_c, err_c, do_access_c, mem_we_c;

  assign req_c = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};

  // In IDLE the live request drives the datapath (zero-wait access at the
  // accept edge); afterwards the captured copy does.
  assign acc_c      = (state == ST_IDLE) ? req_c : cap;
  assign oor_c      = (acc_c.addr[31:2] >= 30'(DEPTH_WORDS));
  assign word_idx_c = acc_c.addr[AW+1:2];
  assign rword_c    = mem[word_idx_c];
  assign err_c      = bad_f3_c | misalign_c | oor_c;

  dmem_lane_align u_lane_align (
    .we         (acc_c.we),
    .funct3     (acc_c.funct3),
    .addr_lo    (acc_c.addr[1:0]),
    .wdata      (acc_c.wdata),
    .rword      (rword_c),
    .be_c       (be_c),
    .wdata_c    (wdata_sh_c),
    .rdata_c    (rdata_ext_c),
    .misalign_c (misalign_c),
    .bad_f3_c   (bad_f3_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    cap_d       = cap;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    do_access_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          cap_d = req_c;
          if (err_c) begin
            state_d     = ST_RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (WAIT_STATES == 0) begin
            do_access_c = 1'b1;
            state_d     = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          do_access_c = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (do_access_c) begin
      rsp_err_d   = 1'b0;
      rsp_rdata_d = acc_c.we ? '0 : rdata_ext_c;
    end
    rsp_valid_d = (state_d == ST_RESP);
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = ~req_ready_d;
  end

  // A store never commits while reset is held, even on a zero-wait accept.
  assign mem_we_c = do_access_c & acc_c.we & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cap       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cap       <= cap_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      req_ready <= req_ready_d;
      busy      <= busy_d;
    end
  end

  // Memory array is not reset; only enabled byte lanes are written.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem[word_idx_c][8*b +: 8] <= wdata_sh_c[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic scored
// against a byte-array memory model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WS    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        z_valid = 1'b0, z_we = 1'b0;
  logic [2:0]  z_funct3 = 3'd0;
  logic [31:0] z_addr = 32'd0, z_wdata = 32'd0;
  logic        z_ready, z_rsp_valid, z_err, z_busy;
  logic [31:0] z_rdata;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(z_valid), .req_ready(z_ready),
    .req_we(z_we), .req_funct3(z_funct3), .req_addr(z_addr),
    .req_wdata(z_wdata), .rsp_valid(z_rsp_valid), .rsp_rdata(z_rdata),
    .rsp_err(z_err), .busy(z_busy));

  int checks = 0;
  int errors = 0;
  logic [7:0] mb [0:4*DEPTH-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit ok;
    case (f3)
      3'd0, 3'd1, 3'd2: ok = 1;
      3'd4, 3'd5:       ok = !we;
      default:          ok = 0;
    endcase
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) ok = 0;
    if (f3 == 3'd2 && (a % 4 != 0)) ok = 0;
    if (a >= 4 * DEPTH) ok = 0;
    return ok;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0: return {{24{mb[a][7]}}, mb[a]};
      3'd1: return {{16{mb[a+1][7]}}, mb[a+1], mb[a]};
      3'd2: return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
      3'd4: return {24'd0, mb[a]};
      3'd5: return {16'd0, mb[a+1], mb[a]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) mb[a+i] = d[8*i +: 8];
  endtask

  // One request on the WAIT_STATES=2 instance; checks handshake, latency and result.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input string tag, output logic [31:0] got);
    bit          legal;
    int          lat, exp_lat;
    logic [31:0] exp_d;
    legal   = model_legal(we, f3, a);
    exp_lat = legal ? WS + 1 : 1;
    exp_d   = 32'd0;
    if (legal && !we) exp_d = model_load(f3, a);
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy, req_ready}, 32'd2);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(rsp_err), 32'(!legal));
    chk({tag, "_rdata"}, rsp_rdata, exp_d);
    got = rsp_rdata;
    if (legal && we) model_store(f3, a, d);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    int pulses;

    // Reset values on both instances.
    #12;
    chk("rst_ready", {30'd0, req_ready, z_ready}, 32'd3);
    chk("rst_busy", {30'd0, busy, z_busy}, 32'd0);
    chk("rst_valid", {30'd0, rsp_valid, z_rsp_valid}, 32'd0);
    chk("rst_err", {30'd0, rsp_err, z_err}, 32'd0);
    chk("rst_rdata", rsp_rdata | z_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Give words 0..15 and the top word defined contents.
    for (int w = 0; w < 16; w++) txn(1'b1, 3'd2, 32'(4*w), $urandom, "init", r);
    txn(1'b1, 3'd2, 32'hFFC, $urandom, "init_top", r);

    txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw10", r);
    txn(1'b0, 3'd2, 32'h10, 32'h0, "lw10", r);
    chk("lw10_lit", r, 32'hDEADBEEF);
    txn(1'b1, 3'd2, 32'h10, 32'h0, "sw10_zero", r);
    txn(1'b1, 3'd0, 32'h13, 32'h80, "sb13", r);
    txn(1'b0, 3'd0, 32'h13, 32'h0, "lb13", r);
    chk("lb13_lit", r, 32'hFFFFFF80);
    txn(1'b0, 3'd4, 32'h13, 32'h0, "lbu13", r);
    chk("lbu13_lit", r, 32'h00000080);
    txn(1'b0, 3'd2, 32'h10, 32'h0, "lw10b", r);
    chk("lw10b_lit", r, 32'h80000000);
    txn(1'b0, 3'd1, 32'h11, 32'h0, "lh11_mis", r);
    txn(1'b1, 3'd1, 32'h11, 32'hFFFF, "sh11_mis", r);
    txn(1'b0, 3'd2, 32'h10, 32'h0, "lw10c", r);
    chk("lw10c_lit", r, 32'h80000000);
    txn(1'b1, 3'd2, 32'(4*DEPTH), 32'h1, "sw_oor", r);
    txn(1'b0, 3'd3, 32'h10, 32'h0, "f3_011", r);
    txn(1'b1, 3'd4, 32'h10, 32'h0, "sbu_ill", r);

    // Reset during WAIT aborts the pending store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_in_wait", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_rst_out", {29'd0, req_ready, busy, rsp_valid}, 32'd4);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("abort_no_pulse", 32'(pulses), 32'd0);
    txn(1'b0, 3'd2, 32'h20, 32'h0, "abort_lw20", r);

    // Zero-wait instance with req_valid held high: accept every other cycle.
    @(negedge clk);
    z_valid = 1'b1; z_we = 1'b1; z_funct3 = 3'd2; z_addr = 32'h40; z_wdata = 32'hA5A50001;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("held_ready", {30'd0, z_ready, z_busy}, (i % 2 == 0) ? 32'd2 : 32'd1);
      chk("held_valid", 32'(z_rsp_valid), 32'(i % 2));
    end
    z_valid = 1'b0;
    @(negedge clk);
    z_valid = 1'b1; z_we = 1'b0; z_funct3 = 3'd5; z_addr = 32'h42;
    @(negedge clk);
    z_valid = 1'b0;
    chk("z_lhu_valid", {31'd0, z_rsp_valid}, 32'd1);
    chk("z_lhu_rdata", z_rdata, 32'h0000A5A5);

    // Random traffic against the byte model.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) a = 32'hFFC + 32'($urandom_range(0, 7));
      else a = 32'($urandom_range(0, 63));
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, "rand", r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
